pitch_snap_requester: RTL
=========================

Name: pitch_snap_requester

Overview:
- Initiator side of the semitone search interface. Accepts detected pitch values on a valid/ready input stream and issues one search per value to the closest-semitone searcher.
- Waits for the searcher's result and packages detected value, snapped value and signed correction on a valid/ready output stream.
- Sits between the pitch detector and the pitch-shift stage; guards against a hung searcher with a timeout.

Parameters:
- WIDTH, 12, bit width of pitch/semitone values (must match the searcher).
- TIMEOUT_CYCLES, 256, max cycles waited for a search result; must be at least 2*BRAM_SIZE+8 of the attached searcher.
- HYST, 2, hysteresis window in LSBs (used only with SNAP_HYST_EN).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- pitch_in  in  WIDTH  detected pitch value
- pitch_valid_in  in  1  pitch_in valid
- pitch_ready_out  out  1  requester can accept a pitch
- start_search_out  out  1  one-cycle search start pulse to the searcher
- search_val_out  out  WIDTH  value to search, held stable for the whole search
- closest_value_in  in  WIDTH  searcher result
- closest_value_found_in  in  1  searcher result valid
- snap_valid_out  out  1  result valid
- snap_ready_in  in  1  downstream accepts result
- detected_out  out  WIDTH  accepted pitch value
- snapped_out  out  WIDTH  snapped semitone value
- correction_out  out  WIDTH+1  signed, snapped_out minus detected_out
- timeout_out  out  1  one-cycle pulse when a search times out
- timeout_count_out  out  8  saturating count of timeouts

Behaviour:
- Reset (async, rst_in=1): state IDLE. All outputs are 0, except pitch_ready_out, which is 0 while reset is asserted and 1 in the first cycle after release. Internal counters and latches clear.
- All outputs are registered.
- States:
  - IDLE: pitch_ready_out=1. On pitch_valid_in&&pitch_ready_out, latch pitch_in.
    - Latched value 0: go to OUTPUT with snapped=0, correction=0, no search issued.
    - Otherwise: go to ISSUE.
  - ISSUE (1 cycle): start_search_out=1; search_val_out=latched value, held until leaving WAIT. Go to WAIT and clear the timeout counter.
  - WAIT:
    - closest_value_found_in is ignored in the first WAIT cycle, because a stale found from the previous search may still be high.
    - From the second WAIT cycle on, the first cycle with found=1 latches closest_value_in, computes correction in WIDTH+1 signed arithmetic, and goes to OUTPUT.
    - Later found assertions are ignored.
  - Timeout: if the counter reaches TIMEOUT_CYCLES-1 without found, set snapped=detected and correction=0, pulse timeout_out for 1 cycle, increment timeout_count_out (saturating at 255), and go to OUTPUT.
  - OUTPUT: snap_valid_out=1, with data held stable until snap_ready_in. On the handshake, return to IDLE; pitch_ready_out rises in the following cycle.
- pitch_ready_out is 0 in every state except IDLE: no buffering, one search in flight.
- start_search_out is never high for more than one cycle per accepted pitch.
- Latency: accept → start_search_out is 1 cycle. found sampled → snap_valid_out is 1 cycle.
- Reset mid-search: immediate return to IDLE. Any searcher result arriving afterwards is ignored because the state is IDLE.
- Correction range: −(2^WIDTH−1) to +(2^WIDTH−1). No saturation is needed.

Optional Feature:
- Macro SNAP_HYST_EN.
- Defined:
  - The requester keeps the last non-timeout detected/snapped pair plus a valid flag; reset clears the flag.
  - If the flag is set and |pitch_in − last_detected| ≤ HYST, no search is issued: go directly to OUTPUT with snapped=last_snapped and correction=last_snapped − pitch_in.
  - last_detected is not updated on a hysteresis hit.
  - Zero input keeps the zero bypass and does not update the pair.
- Undefined: every nonzero pitch issues a search; no hysteresis state exists.

Test Plan:
- Searcher model returns 106 for 104, 12 cycles after start → snapped_out=106, correction_out=+2, detected_out=104. Exactly one start_search_out pulse; search_val_out=104 stable throughout WAIT.
- pitch_in=0 → no start_search_out; snap_valid_out with snapped_out=0, correction_out=0 within 2 cycles.
- Searcher model never asserts found, TIMEOUT_CYCLES=256 → timeout_out pulses once at the 256th WAIT cycle. snapped_out=detected_out=500, correction_out=0, timeout_count_out=1.
- Stale found held high during ISSUE and the first WAIT cycle, real result 212 at cycle 10 → output 212, not the stale value. A second found pulse after the latch is ignored.
- snap_ready_in held 0 for 20 cycles → output data stable and pitch_ready_out=0 for the whole 20 cycles. Assert rst_in during WAIT → all outputs 0 at once; a late found is ignored.
- With SNAP_HYST_EN, HYST=2: first input 104 → search, 106. Second input 105 → no start_search_out, snapped_out=106, correction_out=+1. Third input 110 → search issued.

Source files
------------

// File: rtl/pitch_snap_requester.sv
// Requester for the closest-semitone searcher: one search per accepted pitch, result on a registered valid/ready stream.
// Latency accept->start 1 cycle, found->snap_valid 1 cycle; holds off input until result accepted. SNAP_HYST_EN adds hysteresis reuse.
`timescale 1ns/1ps
module pitch_snap_requester #(
  parameter int WIDTH          = 12,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int HYST           = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pitch_in,
  input  logic             pitch_valid_in,
  output logic             pitch_ready_out,
  output logic             start_search_out,
  output logic [WIDTH-1:0] search_val_out,
  input  logic [WIDTH-1:0] closest_value_in,
  input  logic             closest_value_found_in,
  output logic             snap_valid_out,
  input  logic             snap_ready_in,
  output logic [WIDTH-1:0] detected_out,
  output logic [WIDTH-1:0] snapped_out,
  output logic [WIDTH:0]   correction_out,
  output logic             timeout_out,
  output logic [7:0]       timeout_count_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] sval_q, sval_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] det_q, det_d;
  logic [WIDTH-1:0] snp_q, snp_d;
  logic [WIDTH:0]   corr_q, corr_d;
  logic             to_q, to_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;

`ifdef SNAP_HYST_EN
  logic             last_vld_q, last_vld_d;
  logic [WIDTH-1:0] last_det_q, last_det_d;
  logic [WIDTH-1:0] last_snp_q, last_snp_d;
  logic [WIDTH-1:0] hyst_dist;
  logic             hyst_hit;

  always_comb begin
    hyst_dist = (pitch_in >= last_det_q) ? (pitch_in - last_det_q) : (last_det_q - pitch_in);
    hyst_hit  = last_vld_q && (hyst_dist <= WIDTH'(HYST));
  end
`endif

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    start_d  = 1'b0;
    sval_d   = sval_q;
    vld_d    = vld_q;
    det_d    = det_q;
    snp_d    = snp_q;
    corr_d   = corr_q;
    to_d     = 1'b0;
    to_cnt_d = to_cnt_q;
    cnt_d    = cnt_q;
`ifdef SNAP_HYST_EN
    last_vld_d = last_vld_q;
    last_det_d = last_det_q;
    last_snp_d = last_snp_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (pitch_valid_in && ready_q) begin
          ready_d = 1'b0;
          det_d   = pitch_in;
          if (pitch_in == '0) begin
            snp_d   = '0;
            corr_d  = '0;
            vld_d   = 1'b1;
            state_d = S_OUTPUT;
          end
`ifdef SNAP_HYST_EN
          else if (hyst_hit) begin
            snp_d   = last_snp_q;
            corr_d  = {1'b0, last_snp_q} - {1'b0, pitch_in};
            vld_d   = 1'b1;
            state_d = S_OUTPUT;
          end
`endif
          else begin
            start_d = 1'b1;
            sval_d  = pitch_in;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // cnt_q == 0 is the first WAIT cycle, where a stale found may linger
        if (cnt_q != '0 && closest_value_found_in) begin
          snp_d   = closest_value_in;
          corr_d  = {1'b0, closest_value_in} - {1'b0, det_q};
          vld_d   = 1'b1;
          state_d = S_OUTPUT;
`ifdef SNAP_HYST_EN
          last_vld_d = 1'b1;
          last_det_d = det_q;
          last_snp_d = closest_value_in;
`endif
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          snp_d   = det_q;
          corr_d  = '0;
          to_d    = 1'b1;
          vld_d   = 1'b1;
          state_d = S_OUTPUT;
          if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUTPUT: begin
        if (snap_ready_in) begin
          vld_d   = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      start_q  <= 1'b0;
      sval_q   <= '0;
      vld_q    <= 1'b0;
      det_q    <= '0;
      snp_q    <= '0;
      corr_q   <= '0;
      to_q     <= 1'b0;
      to_cnt_q <= '0;
      cnt_q    <= '0;
`ifdef SNAP_HYST_EN
      last_vld_q <= 1'b0;
      last_det_q <= '0;
      last_snp_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      sval_q   <= sval_d;
      vld_q    <= vld_d;
      det_q    <= det_d;
      snp_q    <= snp_d;
      corr_q   <= corr_d;
      to_q     <= to_d;
      to_cnt_q <= to_cnt_d;
      cnt_q    <= cnt_d;
`ifdef SNAP_HYST_EN
      last_vld_q <= last_vld_d;
      last_det_q <= last_det_d;
      last_snp_q <= last_snp_d;
`endif
    end
  end

  assign pitch_ready_out   = ready_q;
  assign start_search_out  = start_q;
  assign search_val_out    = sval_q;
  assign snap_valid_out    = vld_q;
  assign detected_out      = det_q;
  assign snapped_out       = snp_q;
  assign correction_out    = corr_q;
  assign timeout_out       = to_q;
  assign timeout_count_out = to_cnt_q;

endmodule
